if_prefetch_ahb: RTL and testbench

IF_PREFETCH_AHB -- requirements
Module: if_prefetch_ahb

---
 rtl/if_prefetch_ahb.sv | 151 +++++++++++++++
 tb/tb_if_prefetch_ahb.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_ahb.sv
// Instruction prefetch unit: single-outstanding AHB-Lite read master feeding a small
// instruction FIFO, with redirect flush and a halt on bus error.
module if_prefetch_ahb #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic [2:0]  hsize,
  output logic        hwrite,
  input  logic        hready,
  input  logic [31:0] hrdata,
  input  logic        hresp,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_new,
  output logic        instr_fault
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, HALT} state_t;

  state_t        state_reg, state_next;
  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [31:0]   addr_reg, addr_next;
  logic [31:0]   beat_pc_reg, beat_pc_next;
  logic          discard_reg, discard_next;
  logic [CW-1:0] count_reg;
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   data_mem  [DEPTH];
  logic          fault_mem [DEPTH];

  logic          push, pop, push_fault;
  logic [31:0]   push_data;
  logic [31:0]   redirect_target;

  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
  assign hsize  = 3'b010;
  assign hwrite = 1'b0;
  // haddr comes from its own register so a redirect during a stalled address
  // phase cannot disturb the address the slave is still sampling.
  assign haddr  = addr_reg;

  assign instr_valid = (count_reg != '0);
  assign pop         = if_en && instr_valid;
  assign instr       = instr_valid ? data_mem[rd_ptr_reg]  : 32'h0;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr_reg]    : 32'h0;
  assign instr_fault = instr_valid ? fault_mem[rd_ptr_reg] : 1'b0;
  assign pc_new      = instr_pc + 32'd4;

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    addr_next     = addr_reg;
    beat_pc_next  = beat_pc_reg;
    discard_next  = discard_reg;
    push          = 1'b0;
    push_fault    = 1'b0;
    push_data     = hrdata;
    htrans        = TRANS_IDLE;
    case (state_reg)
      IDLE: begin
        if (!redirect && count_reg != FULL) begin
          state_next = ADDR;
          addr_next  = fetch_pc_reg;
        end
      end
      ADDR: begin
        htrans = TRANS_NONSEQ;
        if (hready) begin
          beat_pc_next = addr_reg;
          state_next   = DATA;
          if (!discard_reg) fetch_pc_next = fetch_pc_reg + 32'd4;
        end
      end
      DATA: begin
        if (hready) begin
          discard_next = 1'b0;
          state_next   = IDLE;
          if (!discard_reg && !redirect) begin
            push = 1'b1;
            if (hresp) begin
              push_data  = 32'h0000_0013;
              push_fault = 1'b1;
              state_next = HALT;
            end
          end
        end
      end
      default: ;
    endcase
    // A redirect always wins the next fetch address; a beat still on the bus is
    // tagged so its response is dropped when it finally completes.
    if (redirect) begin
      fetch_pc_next = redirect_target;
      if (state_reg == HALT) state_next = IDLE;
      if (state_reg == ADDR || (state_reg == DATA && !hready)) discard_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_PC;
      addr_reg     <= RESET_PC;
      beat_pc_reg  <= 32'h0;
      discard_reg  <= 1'b0;
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      addr_reg     <= addr_next;
      beat_pc_reg  <= beat_pc_next;
      discard_reg  <= discard_next;
      if (redirect) begin
        count_reg  <= '0;
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        if (push && !pop)      count_reg <= count_reg + 1'b1;
        else if (!push && pop) count_reg <= count_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]    <= beat_pc_reg;
      data_mem[wr_ptr_reg]  <= push_data;
      fault_mem[wr_ptr_reg] <= push_fault;
    end
  end

endmodule

// File: tb/tb_if_prefetch_ahb.sv
// Directed bench for if_prefetch_ahb: a simple AHB slave returns ~address as data
// and can flag one address as an error; checks follow hand-computed expectations.
module tb_if_prefetch_ahb;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic        hready;
  logic [31:0] hrdata;
  logic        hresp;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_new;
  logic        instr_fault;

  logic        err_en;
  logic [31:0] err_addr;
  logic [31:0] last_addr = 32'h0;
  logic [31:0] beat_addr [0:255];
  int          nbeats = 0;
  int          errors = 0;
  int          checks = 0;
  int          mark;
  int          cyc;

  always #5 clk = ~clk;

  if_prefetch_ahb #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .if_en(if_en), .redirect(redirect),
    .redirect_pc(redirect_pc), .haddr(haddr), .htrans(htrans), .hsize(hsize),
    .hwrite(hwrite), .hready(hready), .hrdata(hrdata), .hresp(hresp),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .pc_new(pc_new), .instr_fault(instr_fault)
  );

  // Slave model: data phase returns the bitwise inverse of the accepted address.
  always @(posedge clk) begin
    if (reset && htrans == 2'b10 && hready) begin
      last_addr <= haddr;
      if (nbeats < 256) beat_addr[nbeats] <= haddr;
      nbeats <= nbeats + 1;
    end
  end
  assign hrdata = ~last_addr;
  assign hresp  = err_en && (last_addr == err_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("check %s ok (%h)", tag, got);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_nonseq(input int maxc, input string tag, output int n);
    n = 0;
    while (htrans != 2'b10 && n < maxc) begin
      step();
      n++;
    end
    if (htrans != 2'b10) check({tag, "_timeout"}, {30'd0, htrans}, 32'h2);
  endtask

  task automatic wait_valid(input int maxc, input string tag);
    int n = 0;
    while (!instr_valid && n < maxc) begin
      step();
      n++;
    end
    if (!instr_valid) check({tag, "_timeout"}, 32'(instr_valid), 32'h1);
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    step();
    redirect    = 1'b0;
    mark        = nbeats;
  endtask

  initial begin
    reset = 1'b0; if_en = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    hready = 1'b1; err_en = 1'b0; err_addr = 32'h0; mark = 0;
    repeat (2) step();
    check("rst_htrans", {30'd0, htrans}, 32'h0);
    check("rst_haddr", haddr, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_pc_new", pc_new, 32'h4);
    check("rst_fault", 32'(instr_fault), 32'h0);
    check("hsize", {29'd0, hsize}, 32'h2);
    check("hwrite", 32'(hwrite), 32'h0);

    // Fill from reset with no consumption.
    reset = 1'b1;
    wait_nonseq(5, "rel", cyc);
    check("rel_latency_le2", 32'(cyc <= 2), 32'h1);
    check("rel_haddr", haddr, 32'h0);
    repeat (20) step();
    check("fill_nbeats", 32'(nbeats - mark), 32'h4);
    for (int k = 0; k < 4; k++) check($sformatf("fill_beat%0d", k), beat_addr[k], 32'(4 * k));
    check("fill_htrans_idle", {30'd0, htrans}, 32'h0);
    check("fill_valid", 32'(instr_valid), 32'h1);
    check("fill_instr_pc", instr_pc, 32'h0);
    check("fill_pc_new", pc_new, 32'h4);
    check("fill_instr", instr, 32'hFFFF_FFFF);

    // One pop from a full FIFO reopens fetching at 0x10.
    if_en = 1'b1;
    step();
    if_en = 1'b0;
    check("pop1_instr_pc", instr_pc, 32'h4);
    check("pop1_instr", instr, ~32'h4);
    wait_nonseq(4, "refill", cyc);
    check("refill_haddr", haddr, 32'h10);
    repeat (3) step();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain_pc%0d", k), instr_pc, 32'(4 + 4 * k));
      check($sformatf("drain_fault%0d", k), 32'(instr_fault), 32'h0);
      if_en = 1'b1;
      step();
    end
    if_en = 1'b0;

    // Address-phase stall at 0x8.
    do_redirect(32'h0);
    cyc = 0;
    while (!(htrans == 2'b10 && haddr == 32'h8) && cyc < 40) begin
      step();
      cyc++;
    end
    check("stall_found", 32'(htrans == 2'b10 && haddr == 32'h8), 32'h1);
    hready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("stall_haddr%0d", k), haddr, 32'h8);
      check($sformatf("stall_htrans%0d", k), {30'd0, htrans}, 32'h2);
    end
    hready = 1'b1;
    step();
    check("data8_htrans", {30'd0, htrans}, 32'h0);
    check("beats_0_4_8", 32'(nbeats - mark), 32'h3);
    check("beat8_addr", beat_addr[mark + 2], 32'h8);

    // Redirect to 0x103 during the data phase of 0x8; consume while empty.
    do_redirect(32'h103);
    if_en = 1'b1;
    check("redir_valid", 32'(instr_valid), 32'h0);
    wait_nonseq(3, "redir", cyc);
    check("redir_haddr", haddr, 32'h100);
    step();
    if_en = 1'b0;
    step();
    check("redir_head_valid", 32'(instr_valid), 32'h1);
    check("redir_head_pc", instr_pc, 32'h100);
    check("redir_head_instr", instr, ~32'h100);

    // Error response on 0xC halts fetching.
    err_en = 1'b1; err_addr = 32'hC;
    do_redirect(32'h0);
    repeat (30) step();
    check("err_nbeats", 32'(nbeats - mark), 32'h4);
    check("err_beat_addr", beat_addr[mark + 3], 32'hC);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("err_pop_pc%0d", k), instr_pc, 32'(4 * k));
      check($sformatf("err_pop_fault%0d", k), 32'(instr_fault), 32'h0);
      if_en = 1'b1;
      step();
    end
    if_en = 1'b0;
    check("err_head_pc", instr_pc, 32'hC);
    check("err_head_fault", 32'(instr_fault), 32'h1);
    check("err_head_instr", instr, 32'h13);
    check("err_head_pc_new", pc_new, 32'h10);
    repeat (10) step();
    check("halt_no_fetch", 32'(nbeats - mark), 32'h4);
    check("halt_htrans", {30'd0, htrans}, 32'h0);
    err_en = 1'b0;
    do_redirect(32'h200);
    check("resume_valid", 32'(instr_valid), 32'h0);
    wait_nonseq(3, "resume", cyc);
    check("resume_haddr", haddr, 32'h200);

    // Address wrap at the top of memory.
    do_redirect(32'hFFFF_FFFC);
    cyc = 0;
    while (nbeats - mark < 2 && cyc < 20) begin
      step();
      cyc++;
    end
    check("wrap_nbeats_ge2", 32'(nbeats - mark >= 2), 32'h1);
    check("wrap_beat0", beat_addr[mark], 32'hFFFF_FFFC);
    check("wrap_beat1", beat_addr[mark + 1], 32'h0);
    wait_valid(10, "wrap");
    check("wrap_head_pc", instr_pc, 32'hFFFF_FFFC);
    check("wrap_pc_new", pc_new, 32'h0);
    check("wrap_instr", instr, 32'h3);

    // Reset in the middle of a stalled address phase.
    wait_nonseq(20, "mid", cyc);
    hready = 1'b0;
    step();
    reset = 1'b0;
    #1;
    check("midrst_htrans", {30'd0, htrans}, 32'h0);
    check("midrst_haddr", haddr, 32'h0);
    check("midrst_valid", 32'(instr_valid), 32'h0);
    check("midrst_pc_new", pc_new, 32'h4);
    step();
    reset = 1'b1;
    hready = 1'b1;
    wait_nonseq(5, "rel2", cyc);
    check("rel2_latency_le2", 32'(cyc <= 2), 32'h1);
    check("rel2_haddr", haddr, 32'h0);
    wait_valid(10, "rel2");
    check("rel2_head_pc", instr_pc, 32'h0);
    check("rel2_head_instr", instr, 32'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
